// File: rtl/xbar_pipe.sv
// Registered NxN crossbar: each output takes the lowest-ranked valid granted source; multicast allowed.
// Latency: 1 cycle from inputs to out_data/out_valid; the conflict counter also updates 1 cycle later.
// Backpressure: stall holds the output registers; conflict counting keeps running. Macro XBAR_APV_FWD_EN adds apv_out.
module xbar_pipe #(
  parameter int NUM_PORT = 4,
  parameter int DATA_W   = 64,
  parameter int CNT_W    = 8,
  localparam int IDX_W   = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORT*DATA_W-1:0]    in_data,
  input  logic [NUM_PORT-1:0]           in_valid,
  input  logic [NUM_PORT*IDX_W-1:0]     indir_rank,
  input  logic [NUM_PORT*NUM_PORT-1:0]  alloc_pv,
  input  logic                          stall,
  input  logic                          clr_cnt,
  output logic [NUM_PORT*DATA_W-1:0]    out_data,
  output logic [NUM_PORT-1:0]           out_valid,
  output logic [CNT_W-1:0]              conflict_cnt,
  output logic                          conflict_sticky
`ifdef XBAR_APV_FWD_EN
  ,
  output logic [NUM_PORT*NUM_PORT-1:0]  apv_out
`endif
);

  // Per-rank resolved source: valid only when the index is in range and that input is valid.
  logic [NUM_PORT-1:0] rank_ok;
  logic [DATA_W-1:0]   rank_data [NUM_PORT];

  // Per-output winner of this cycle.
  logic [NUM_PORT-1:0] sel_vld;
  logic [DATA_W-1:0]   sel_data [NUM_PORT];
  logic                conflict;
`ifdef XBAR_APV_FWD_EN
  logic [NUM_PORT-1:0] sel_apv [NUM_PORT];
`endif

  // Resolve each rank's source; an out-of-range index matches no input, so the rank grants nothing.
  always_comb begin
    rank_ok = '0;
    for (int r = 0; r < NUM_PORT; r++) begin
      rank_data[r] = '0;
      for (int i = 0; i < NUM_PORT; i++) begin
        if (indir_rank[r*IDX_W +: IDX_W] == i[IDX_W-1:0]) begin
          rank_ok[r]   = in_valid[i];
          rank_data[r] = in_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Scan ranks low to high per output: first effective claim wins, any further one flags a conflict.
  always_comb begin
    sel_vld  = '0;
    conflict = 1'b0;
    for (int o = 0; o < NUM_PORT; o++) begin
      sel_data[o] = '0;
`ifdef XBAR_APV_FWD_EN
      sel_apv[o] = '0;
`endif
      for (int r = 0; r < NUM_PORT; r++) begin
        if (rank_ok[r] && alloc_pv[r*NUM_PORT + o]) begin
          if (sel_vld[o]) begin
            conflict = 1'b1;
          end else begin
            sel_vld[o]  = 1'b1;
            sel_data[o] = rank_data[r];
`ifdef XBAR_APV_FWD_EN
            sel_apv[o] = alloc_pv[r*NUM_PORT +: NUM_PORT];
`endif
          end
        end
      end
    end
  end

  // Output registers: load winners unless stalled; idle outputs keep their last flit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
`ifdef XBAR_APV_FWD_EN
      apv_out   <= '0;
`endif
    end else if (!stall) begin
      out_valid <= sel_vld;
      for (int o = 0; o < NUM_PORT; o++) begin
        if (sel_vld[o]) begin
          out_data[o*DATA_W +: DATA_W] <= sel_data[o];
        end
`ifdef XBAR_APV_FWD_EN
        apv_out[o*NUM_PORT +: NUM_PORT] <= sel_vld[o] ? sel_apv[o] : '0;
`endif
      end
    end
  end

  // Conflict statistics: clear wins over a same-cycle conflict; the counter saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt    <= '0;
      conflict_sticky <= 1'b0;
    end else if (clr_cnt) begin
      conflict_cnt    <= '0;
      conflict_sticky <= 1'b0;
    end else if (conflict) begin
      conflict_sticky <= 1'b1;
      if (conflict_cnt != {CNT_W{1'b1}}) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xbar_pipe.sv
module tb_xbar_pipe;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int CW = 2;
  localparam int IW = 2;

  localparam logic [63:0] DA = 64'hAAAA_0000_0000_0001;
  localparam logic [63:0] DB = 64'hBBBB_0000_0000_0002;
  localparam logic [63:0] DC = 64'hCCCC_0000_0000_0003;
  localparam logic [63:0] DD = 64'hDDDD_0000_0000_0004;
  localparam logic [63:0] DE = 64'hEEEE_0000_0000_0005;
  localparam logic [63:0] DF = 64'hFFFF_0000_0000_0006;
  localparam logic [63:0] DG = 64'h1111_0000_0000_0007;
  localparam logic [63:0] DH = 64'h2222_0000_0000_0008;
  localparam logic [63:0] BF = 64'h0000_0000_0000_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT (NUM_PORT=4, CNT_W=2 to reach saturation quickly)
  logic [NP*DW-1:0] in_data = '0;
  logic [NP-1:0]    in_valid = '0;
  logic [NP*IW-1:0] indir_rank = '0;
  logic [NP*NP-1:0] alloc_pv = '0;
  logic             stall = 1'b0;
  logic             clr_cnt = 1'b0;
  logic [NP*DW-1:0] out_data;
  logic [NP-1:0]    out_valid;
  logic [CW-1:0]    conflict_cnt;
  logic             conflict_sticky;
`ifdef XBAR_APV_FWD_EN
  logic [NP*NP-1:0] apv_out;
`endif

  xbar_pipe #(.NUM_PORT(NP), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .indir_rank(indir_rank), .alloc_pv(alloc_pv), .stall(stall), .clr_cnt(clr_cnt),
    .out_data(out_data), .out_valid(out_valid), .conflict_cnt(conflict_cnt),
    .conflict_sticky(conflict_sticky)
`ifdef XBAR_APV_FWD_EN
    , .apv_out(apv_out)
`endif
  );

  // small DUT (NUM_PORT=3) so rank index 3 is out of range
  logic [23:0] s_in_data = '0;
  logic [2:0]  s_in_valid = '0;
  logic [5:0]  s_indir_rank = '0;
  logic [8:0]  s_alloc_pv = '0;
  logic        s_stall = 1'b0;
  logic        s_clr_cnt = 1'b0;
  logic [23:0] s_out_data;
  logic [2:0]  s_out_valid;
  logic [3:0]  s_conflict_cnt;
  logic        s_conflict_sticky;
`ifdef XBAR_APV_FWD_EN
  logic [8:0]  s_apv_out;
`endif

  xbar_pipe #(.NUM_PORT(3), .DATA_W(8), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .in_valid(s_in_valid),
    .indir_rank(s_indir_rank), .alloc_pv(s_alloc_pv), .stall(s_stall), .clr_cnt(s_clr_cnt),
    .out_data(s_out_data), .out_valid(s_out_valid), .conflict_cnt(s_conflict_cnt),
    .conflict_sticky(s_conflict_sticky)
`ifdef XBAR_APV_FWD_EN
    , .apv_out(s_apv_out)
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [NP*DW-1:0] din;
    logic [NP-1:0]    vld;
    logic [NP*IW-1:0] rank;
    logic [NP*NP-1:0] apv;
    logic [NP*DW-1:0] exp_d;
    logic [NP-1:0]    exp_v;
    logic             conf;
  } vec_t;

  typedef struct {
    logic [NP*DW-1:0] exp_d;
    logic [NP-1:0]    exp_v;
    logic [CW-1:0]    exp_c;
    logic             exp_s;
  } exp_t;

  vec_t tbl [7];
  exp_t sb [$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [NP*DW-1:0] d, input logic [NP-1:0] v,
                         input logic [CW-1:0] c, input logic s);
    chk({name, ".data"}, out_data, d);
    chk({name, ".valid"}, out_valid, v);
    chk({name, ".cnt"}, conflict_cnt, c);
    chk({name, ".sticky"}, conflict_sticky, s);
  endtask

  task automatic drive(input logic [NP*DW-1:0] d, input logic [NP-1:0] v, input logic [NP*IW-1:0] rk,
                       input logic [NP*NP-1:0] ap, input logic st, input logic cl);
    in_data = d; in_valid = v; indir_rank = rk; alloc_pv = ap; stall = st; clr_cnt = cl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [CW-1:0] mcnt;
    logic          mstk;
    exp_t          e;

    // rank packing: rank r at [2r+:2]; 8'hE4 = ranks {0,1,2,3}. alloc: rank r at [4r+:4].
    tbl[0] = '{{DD,DC,DB,DA}, 4'hF, 8'hE4, 16'h8421, {DD,DC,DB,DA}, 4'hF, 1'b0};
    tbl[1] = '{{DH,DG,DF,DE}, 4'hF, 8'hE4, 16'h1248, {DE,DF,DG,DH}, 4'hF, 1'b0};
    tbl[2] = '{{64'h0,BF,64'h0,64'h0}, 4'b0100, 8'hE6, 16'h0007, {DE,BF,BF,BF}, 4'b0111, 1'b0};
    tbl[3] = '{{DD,DC,DB,DA}, 4'b1101, 8'hE5, 16'h0001, {DE,BF,BF,BF}, 4'b0000, 1'b0};
    tbl[4] = '{{DD,DC,DB,DA}, 4'hF, 8'hE1, 16'h8411, {DD,DC,BF,DB}, 4'b1101, 1'b1};
    tbl[5] = '{{DH,DG,DF,DE}, 4'hF, 8'hE4, 16'h0033, {DD,DC,DE,DE}, 4'b0011, 1'b1};
    tbl[6] = '{{DD,DC,DB,DA}, 4'b1101, 8'hE4, 16'h0011, {DD,DC,DE,DA}, 4'b0001, 1'b0};

    // reset state, asserted from time 0
    #12;
    chk_out("reset", '0, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // table vectors through the scoreboard
    mcnt = '0;
    mstk = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].din, tbl[i].vld, tbl[i].rank, tbl[i].apv, 1'b0, 1'b0);
      if (tbl[i].conf) begin
        mstk = 1'b1;
        if (mcnt != '1) mcnt = mcnt + 1'b1;
      end
      e.exp_d = tbl[i].exp_d; e.exp_v = tbl[i].exp_v; e.exp_c = mcnt; e.exp_s = mstk;
      sb.push_back(e);
      step();
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard empty at vector %0d", i);
      end else begin
        e = sb.pop_front();
        chk_out($sformatf("vec%0d", i), e.exp_d, e.exp_v, e.exp_c, e.exp_s);
      end
    end

    // clear with no conflict
    drive('0, '0, 8'hE4, '0, 1'b0, 1'b1);
    step();
    chk("clr.cnt", conflict_cnt, 0);
    chk("clr.sticky", conflict_sticky, 0);
    chk("clr.valid", out_valid, 0);

    // three conflict cycles on output 0 (ranks 0 and 1), rank 0 wins
    for (int k = 1; k <= 3; k++) begin
      drive({DD,DC,DB,DA}, 4'hF, 8'hE4, 16'h0011, 1'b0, 1'b0);
      step();
      chk($sformatf("conf%0d.cnt", k), conflict_cnt, k);
      chk($sformatf("conf%0d.out0", k), out_data[63:0], DA);
      chk($sformatf("conf%0d.valid", k), out_valid, 4'b0001);
    end
    chk("conf.sticky", conflict_sticky, 1);

    // clear beats a simultaneous conflict
    drive({DD,DC,DB,DA}, 4'hF, 8'hE4, 16'h0011, 1'b0, 1'b1);
    step();
    chk("clrconf.cnt", conflict_cnt, 0);
    chk("clrconf.sticky", conflict_sticky, 0);

    // saturation: 6 conflict cycles with a 2-bit counter
    for (int k = 1; k <= 6; k++) begin
      drive({DD,DC,DB,DA}, 4'hF, 8'hE4, 16'h0011, 1'b0, 1'b0);
      step();
      chk($sformatf("sat%0d.cnt", k), conflict_cnt, (k > 3) ? 3 : k);
    end
    chk("sat.sticky", conflict_sticky, 1);

    // stall: register P1 (with clear), hold through two stalled cycles, then P2
    drive({DD,DC,DB,DA}, 4'hF, 8'hE4, 16'h8421, 1'b0, 1'b1);
    step();
    chk_out("p1", {DD,DC,DB,DA}, 4'hF, 0, 1'b0);
    drive({DH,DG,DF,DE}, 4'hF, 8'hE4, 16'h1248, 1'b1, 1'b0);
    step();
    chk_out("stall1", {DD,DC,DB,DA}, 4'hF, 0, 1'b0);
    drive({DH,DG,DF,DE}, 4'hF, 8'hE4, 16'h0011, 1'b1, 1'b0);
    step();
    chk_out("stall2", {DD,DC,DB,DA}, 4'hF, 1, 1'b1);
    drive({DH,DG,DF,DE}, 4'hF, 8'hE4, 16'h1248, 1'b0, 1'b0);
    step();
    chk_out("unstall", {DE,DF,DG,DH}, 4'hF, 1, 1'b1);

    // asynchronous reset between edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst", '0, '0, 0, 1'b0);
`ifdef XBAR_APV_FWD_EN
    chk("arst.apv", apv_out, 0);
`endif
    drive('0, '0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // first edge after reset behaves normally
    drive({DD,DC,DB,DA}, 4'hF, 8'hE4, 16'h8421, 1'b0, 1'b0);
    step();
    chk_out("postrst", {DD,DC,DB,DA}, 4'hF, 0, 1'b0);
`ifdef XBAR_APV_FWD_EN
    chk("postrst.apv", apv_out, 16'h8421);
`endif

    // out-of-range rank index on the 3-port instance
    s_in_data = {8'h33, 8'h22, 8'h11};
    s_in_valid = 3'b111;
    s_indir_rank = 6'b00_00_11;
    s_alloc_pv = 9'b000_000_111;
    step();
    chk("oor.valid", s_out_valid, 0);
    chk("oor.cnt", s_conflict_cnt, 0);
    s_indir_rank = 6'b01_00_11;
    s_alloc_pv = 9'b000_001_001;
    step();
    chk("oor2.valid", s_out_valid, 3'b001);
    chk("oor2.data", s_out_data, 24'h00_00_11);
    chk("oor2.cnt", s_conflict_cnt, 0);
    s_indir_rank = 6'b00_00_10;
    step();
    chk("p3conf.data", s_out_data, 24'h00_00_33);
    chk("p3conf.cnt", s_conflict_cnt, 1);
    chk("p3conf.sticky", s_conflict_sticky, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
